// File: rtl/exe_stage_module.sv
// ARM execute stage: forwarding, Val2, ALU, branch target, NZCV; 1-cycle EXE/MEM register.
// Branch outputs are combinational; freeze holds the EXE/MEM register and status register.
module exe_stage_module #(
   parameter int ADDRESS_LEN               = 32,
   parameter int REGISTER_FILE_LEN         = 32,
   parameter int REGISTER_FILE_ADDRESS_LEN = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 freeze,
   input  logic                                 wb_en_in,
   input  logic                                 mem_r_en_in,
   input  logic                                 mem_w_en_in,
   input  logic                                 branch_taken_in,
   input  logic                                 status_reg_en_in,
   input  logic                                 imm_in,
   input  logic [3:0]                           exec_cmd,
   input  logic [ADDRESS_LEN-1:0]               pc_in,
   input  logic [REGISTER_FILE_LEN-1:0]         val_r_n,
   input  logic [REGISTER_FILE_LEN-1:0]         val_r_m,
   input  logic [11:0]                          shift_operand,
   input  logic [23:0]                          signed_imm_24,
   input  logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_in,
   input  logic [1:0]                           sel_src_1,
   input  logic [1:0]                           sel_src_2,
   input  logic [REGISTER_FILE_LEN-1:0]         mem_fwd,
   input  logic [REGISTER_FILE_LEN-1:0]         wb_fwd,
   output logic                                 branch_taken,
   output logic [ADDRESS_LEN-1:0]               branch_address,
   output logic [3:0]                           status_reg,
   output logic                                 wb_en_out,
   output logic                                 mem_r_en_out,
   output logic                                 mem_w_en_out,
   output logic [REGISTER_FILE_LEN-1:0]         alu_result,
   output logic [REGISTER_FILE_LEN-1:0]         st_val,
   output logic [REGISTER_FILE_ADDRESS_LEN-1:0] dest_out
);
   localparam int W = REGISTER_FILE_LEN;

   logic [W-1:0]   w_op1;
   logic [W-1:0]   w_fwd_rm;
   logic [W-1:0]   w_val2;
   logic [W-1:0]   w_imm32;
   logic [2*W-1:0] w_imm_rot;
   logic [2*W-1:0] w_rm_rot;
   logic [4:0]     w_sh_amt;
   logic [W:0]     w_sum;
   logic [W-1:0]   w_res;
   logic           w_n, w_z, w_c, w_v, w_nz_upd;

   always_comb begin
      case (sel_src_1)
         2'b01:   w_op1 = mem_fwd;
         2'b10:   w_op1 = wb_fwd;
         default: w_op1 = val_r_n;
      endcase
      case (sel_src_2)
         2'b01:   w_fwd_rm = mem_fwd;
         2'b10:   w_fwd_rm = wb_fwd;
         default: w_fwd_rm = val_r_m;
      endcase
   end

   // Rotations use a doubled operand so an amount of zero naturally yields the input.
   assign w_sh_amt  = shift_operand[11:7];
   assign w_imm32   = {{(W-8){1'b0}}, shift_operand[7:0]};
   assign w_imm_rot = {w_imm32, w_imm32} >> {shift_operand[11:8], 1'b0};
   assign w_rm_rot  = {w_fwd_rm, w_fwd_rm} >> w_sh_amt;

   always_comb begin
      w_val2 = w_fwd_rm;
      if (mem_r_en_in || mem_w_en_in) begin
         w_val2 = {{(W-12){1'b0}}, shift_operand};
      end else if (imm_in) begin
         w_val2 = w_imm_rot[W-1:0];
      end else begin
         case (shift_operand[6:5])
            2'b00:   w_val2 = w_fwd_rm << w_sh_amt;
            2'b01:   w_val2 = w_fwd_rm >> w_sh_amt;
            2'b10:   w_val2 = $signed(w_fwd_rm) >>> w_sh_amt;
            default: w_val2 = w_rm_rot[W-1:0];
         endcase
      end
   end

   always_comb begin
      w_sum    = '0;
      w_res    = '0;
      w_n      = status_reg[3];
      w_z      = status_reg[2];
      w_c      = status_reg[1];
      w_v      = status_reg[0];
      w_nz_upd = 1'b1;
      case (exec_cmd)
         4'b0001: w_res = w_val2;
         4'b1001: w_res = ~w_val2;
         4'b0010, 4'b0011: begin
            w_sum = {1'b0, w_op1} + {1'b0, w_val2}
                  + {{W{1'b0}}, (exec_cmd[0] & status_reg[1])};
            w_res = w_sum[W-1:0];
            w_c   = w_sum[W];
            w_v   = (w_op1[W-1] == w_val2[W-1]) && (w_res[W-1] != w_op1[W-1]);
         end
         4'b0100, 4'b0101: begin
            // Subtract as op1 + ~val2 + carry-in; carry-out is the ARM not-borrow.
            w_sum = {1'b0, w_op1} + {1'b0, ~w_val2}
                  + {{W{1'b0}}, (exec_cmd[0] ? status_reg[1] : 1'b1)};
            w_res = w_sum[W-1:0];
            w_c   = w_sum[W];
            w_v   = (w_op1[W-1] != w_val2[W-1]) && (w_res[W-1] != w_op1[W-1]);
         end
         4'b0110: w_res = w_op1 & w_val2;
         4'b0111: w_res = w_op1 | w_val2;
         4'b1000: w_res = w_op1 ^ w_val2;
         default: w_nz_upd = 1'b0;
      endcase
      if (w_nz_upd) begin
         w_n = w_res[W-1];
         w_z = (w_res == '0);
      end
   end

   assign branch_taken   = branch_taken_in;
   assign branch_address = pc_in + {{(ADDRESS_LEN-26){signed_imm_24[23]}}, signed_imm_24, 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         status_reg   <= '0;
         wb_en_out    <= 1'b0;
         mem_r_en_out <= 1'b0;
         mem_w_en_out <= 1'b0;
         alu_result   <= '0;
         st_val       <= '0;
         dest_out     <= '0;
      end else if (!freeze) begin
         if (status_reg_en_in) begin
            status_reg <= {w_n, w_z, w_c, w_v};
         end
         wb_en_out    <= wb_en_in;
         mem_r_en_out <= mem_r_en_in;
         mem_w_en_out <= mem_w_en_in;
         alu_result   <= w_res;
         st_val       <= w_fwd_rm;
         dest_out     <= dest_in;
      end
   end
endmodule
